// File: rtl/instruction_memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_memory_if                                                |
// | Fetch and byte-load bundle between PC/loader and instruction store.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface instruction_memory_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int c_CW = $clog2(DEPTH_WORDS) + 1;

  logic [31:0]     pcAddress;
  logic [31:0]     instruction;
  logic            instructionValid;
  logic            addressFault;
  logic            loadEnable;
  logic            loadByteValid;
  logic [7:0]      loadByte;
  logic            loadReady;
  logic [c_CW-1:0] loadCount;
  logic            loadDone;

  modport master (
    output pcAddress, loadEnable, loadByteValid, loadByte,
    input  instruction, instructionValid, addressFault, loadReady, loadCount, loadDone
  );

  modport slave (
    input  pcAddress, loadEnable, loadByteValid, loadByte,
    output instruction, instructionValid, addressFault, loadReady, loadCount, loadDone
  );
endinterface
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_memory                                                   |
// | Registered instruction fetch with a big-endian byte-stream loader.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_memory #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  instruction_memory_if.slave bus
);
  localparam int          c_AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] c_SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_byte_idx;
  logic [c_AW-1:0] r_word_idx;
  logic [c_AW:0]   r_load_count;
  logic [31:0]     r_asm;
  logic            r_load_done;
  logic [31:0]     r_instruction;
  logic            r_valid;
  logic            r_fault;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     w_offset;
  logic            w_fetch_ok;
  logic            w_load_ready;
  logic            w_accept;
  logic            w_write;
  logic [31:0]     w_word;

  // Wrapping subtraction pushes addresses below the base far out of range.
  assign w_offset     = bus.pcAddress - BASE_ADDR;
  assign w_fetch_ok   = (w_offset < c_SPAN) && (bus.pcAddress[1:0] == 2'b00);
  assign w_load_ready = (r_state == LOAD) && bus.loadEnable;
  assign w_accept     = w_load_ready && bus.loadByteValid;
  assign w_write      = w_accept && (r_byte_idx == 2'd3);
  assign w_word       = {r_asm[23:0], bus.loadByte};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (bus.loadEnable) w_next_state = LOAD;
      LOAD: begin
        if (!bus.loadEnable)
          w_next_state = RUN;
        else if (w_write && (&r_word_idx)) // depth is a power of two
          w_next_state = FULL;
      end
      FULL:    if (!bus.loadEnable) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_byte_idx    <= 2'd0;
      r_word_idx    <= '0;
      r_load_count  <= '0;
      r_asm         <= 32'd0;
      r_load_done   <= 1'b0;
      r_instruction <= 32'd0;
      r_valid       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_load_done <= (r_state != RUN) && !bus.loadEnable;

      if ((r_state == RUN) && bus.loadEnable) begin
        r_byte_idx   <= 2'd0;
        r_word_idx   <= '0;
        r_load_count <= '0;
      end else if (w_accept) begin
        r_asm      <= w_word;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_word_idx   <= r_word_idx + c_AW'(1);
          r_load_count <= r_load_count + (c_AW + 1)'(1);
        end
      end

      // Fetch only runs in RUN, so it never overlaps a store write.
      if (r_state == RUN) begin
        if (w_fetch_ok) begin
          r_instruction <= mem[w_offset[c_AW+1:2]];
          r_valid       <= 1'b1;
          r_fault       <= 1'b0;
        end else begin
          r_instruction <= 32'd0;
          r_valid       <= 1'b0;
          r_fault       <= 1'b1;
        end
      end else begin
        r_instruction <= 32'd0;
        r_valid       <= 1'b0;
        r_fault       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write)
      mem[r_word_idx] <= w_word;
  end

  assign bus.instruction      = r_instruction;
  assign bus.instructionValid = r_valid;
  assign bus.addressFault     = r_fault;
  assign bus.loadReady        = w_load_ready;
  assign bus.loadCount        = r_load_count;
  assign bus.loadDone         = r_load_done;
endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_memory                                                |
// | Directed bench: fetch, load, faults, full boundary, reset mid-load.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instruction_memory;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  instruction_memory_if #(.DEPTH_WORDS(1024)) ifa ();
  instruction_memory_if #(.DEPTH_WORDS(4))    ifb ();

  instruction_memory #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  instruction_memory #(.DEPTH_WORDS(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  task automatic a_byte(input logic [7:0] b);
    @(negedge clk);
    ifa.loadByteValid = 1'b1;
    ifa.loadByte      = b;
  endtask

  task automatic b_byte(input logic [7:0] b);
    @(negedge clk);
    ifb.loadByteValid = 1'b1;
    ifb.loadByte      = b;
  endtask

  task automatic test_reset();
    ifa.pcAddress = BASE; ifa.loadEnable = 0; ifa.loadByteValid = 0; ifa.loadByte = 0;
    ifb.pcAddress = BASE; ifb.loadEnable = 0; ifb.loadByteValid = 0; ifb.loadByte = 0;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({ifa.instruction, ifa.instructionValid, ifa.addressFault, ifa.loadReady,
           ifa.loadCount, ifa.loadDone} !== '0)
        $display("FAIL reset_outputs cycle %0d: got %h/%b/%b/%b/%0d/%b want all zero", c,
                 ifa.instruction, ifa.instructionValid, ifa.addressFault, ifa.loadReady,
                 ifa.loadCount, ifa.loadDone);
      else passed++;
    end
    total++;
    if ({ifb.instructionValid, ifb.addressFault, ifb.loadCount} !== '0)
      $display("FAIL reset_outputs_d4: got %b/%b/%0d want 0/0/0",
               ifb.instructionValid, ifb.addressFault, ifb.loadCount);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ifa.instructionValid !== 1'b1 || ifa.addressFault !== 1'b0)
      $display("FAIL first_fetch: got valid=%b fault=%b want valid=1 fault=0",
               ifa.instructionValid, ifa.addressFault);
    else passed++;
  endtask

  task automatic test_load_two_words();
    logic [7:0] prog [8];
    prog = '{8'h24, 8'h00, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h10, 8'h01};
    @(negedge clk);
    ifa.loadEnable = 1'b1;
    ifa.pcAddress  = BASE + 32'd2;
    for (int i = 0; i < 8; i++) begin
      a_byte(prog[i]);
      if (i == 0) begin
        total++;
        if (ifa.loadReady !== 1'b1)
          $display("FAIL load_ready_in_load: got %b want 1", ifa.loadReady);
        else passed++;
      end
      if (i == 1) begin
        total++;
        if ({ifa.instruction, ifa.instructionValid, ifa.addressFault} !== '0)
          $display("FAIL fetch_idle_in_load: got %h/%b/%b want 0/0/0",
                   ifa.instruction, ifa.instructionValid, ifa.addressFault);
        else passed++;
      end
    end
    @(negedge clk);
    ifa.loadByteValid = 1'b0;
    ifa.loadEnable    = 1'b0;
    total++;
    if (ifa.loadCount !== 2)
      $display("FAIL load2_count: got %0d want 2", ifa.loadCount);
    else passed++;
    @(negedge clk);
    total++;
    if (ifa.loadDone !== 1'b1 || ifa.loadReady !== 1'b0)
      $display("FAIL load2_done: got done=%b ready=%b want done=1 ready=0",
               ifa.loadDone, ifa.loadReady);
    else passed++;
    ifa.pcAddress = BASE;
    @(negedge clk);
    total++;
    if (ifa.loadDone !== 1'b0 || ifa.instruction !== 32'h2400_0005 || ifa.instructionValid !== 1'b1)
      $display("FAIL load2_word0: got done=%b instr=%h valid=%b want 0/24000005/1",
               ifa.loadDone, ifa.instruction, ifa.instructionValid);
    else passed++;
    ifa.pcAddress = BASE + 32'd4;
    @(negedge clk);
    total++;
    if (ifa.instruction !== 32'h3C01_1001)
      $display("FAIL load2_word1: got %h want 3c011001", ifa.instruction);
    else passed++;
  endtask

  task automatic test_partial_and_gaps();
    @(negedge clk);
    ifa.loadEnable = 1'b1;
    a_byte(8'h11);
    a_byte(8'h22);
    @(negedge clk) ifa.loadByteValid = 1'b0;
    a_byte(8'h33);
    a_byte(8'h44);
    @(negedge clk) ifa.loadByteValid = 1'b0;
    a_byte(8'h55);
    a_byte(8'h66);
    a_byte(8'h77);
    @(negedge clk);
    ifa.loadEnable    = 1'b0;
    ifa.loadByteValid = 1'b1;
    ifa.loadByte      = 8'h88;
    #1;
    total++;
    if (ifa.loadReady !== 1'b0 || ifa.loadCount !== 1)
      $display("FAIL partial_fall_ready: got ready=%b count=%0d want 0/1",
               ifa.loadReady, ifa.loadCount);
    else passed++;
    @(negedge clk);
    ifa.loadByteValid = 1'b0;
    total++;
    if (ifa.loadDone !== 1'b1 || ifa.loadCount !== 1)
      $display("FAIL partial_count: got done=%b count=%0d want 1/1", ifa.loadDone, ifa.loadCount);
    else passed++;
    ifa.pcAddress = BASE;
    @(negedge clk);
    total++;
    if (ifa.instruction !== 32'h1122_3344)
      $display("FAIL partial_word0: got %h want 11223344", ifa.instruction);
    else passed++;
    ifa.pcAddress = BASE + 32'd4;
    @(negedge clk);
    total++;
    if (ifa.instruction !== 32'h3C01_1001)
      $display("FAIL partial_word1_kept: got %h want 3c011001", ifa.instruction);
    else passed++;
  endtask

  task automatic test_empty_load();
    @(negedge clk) ifa.loadEnable = 1'b1;
    @(negedge clk) ifa.loadEnable = 1'b0;
    @(negedge clk);
    total++;
    if (ifa.loadDone !== 1'b1 || ifa.loadCount !== 0)
      $display("FAIL empty_load: got done=%b count=%0d want 1/0", ifa.loadDone, ifa.loadCount);
    else passed++;
    @(negedge clk);
    total++;
    if (ifa.loadDone !== 1'b0)
      $display("FAIL empty_load_pulse: got done=%b want 0", ifa.loadDone);
    else passed++;
  endtask

  // Back-to-back addresses: each result appears one cycle after its address.
  task automatic test_back_to_back_faults();
    logic [31:0] addr  [6];
    logic        evld  [6];
    logic        eflt  [6];
    logic        chk   [6];
    logic [31:0] einst [6];
    addr  = '{BASE + 32'd2, 32'h003F_FFFC, BASE + 32'd4096, BASE + 32'd4092, BASE, BASE + 32'd4};
    evld  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eflt  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    chk   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    einst = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h1122_3344, 32'h3C01_1001};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (ifa.instructionValid !== evld[i-1] || ifa.addressFault !== eflt[i-1] ||
            (chk[i-1] && ifa.instruction !== einst[i-1]))
          $display("FAIL fetch_%h: got instr=%h valid=%b fault=%b want instr=%h valid=%b fault=%b",
                   addr[i-1], ifa.instruction, ifa.instructionValid, ifa.addressFault,
                   einst[i-1], evld[i-1], eflt[i-1]);
        else passed++;
      end
      if (i < 6) ifa.pcAddress = addr[i];
    end
  endtask

  task automatic test_full_boundary();
    logic [31:0] exp_word;
    @(negedge clk);
    ifb.loadEnable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      b_byte(8'(k));
      if (k == 16) begin
        total++;
        if (ifb.loadReady !== 1'b1 || ifb.loadCount !== 3)
          $display("FAIL full_before_last: got ready=%b count=%0d want 1/3",
                   ifb.loadReady, ifb.loadCount);
        else passed++;
      end
    end
    for (int k = 17; k <= 20; k++) begin
      b_byte(8'(8'hA0 + k));
      if (k == 17) begin
        total++;
        if (ifb.loadReady !== 1'b0 || ifb.loadCount !== 4)
          $display("FAIL full_entered: got ready=%b count=%0d want 0/4",
                   ifb.loadReady, ifb.loadCount);
        else passed++;
      end
    end
    @(negedge clk);
    ifb.loadByteValid = 1'b0;
    ifb.loadEnable    = 1'b0;
    total++;
    if (ifb.loadCount !== 4)
      $display("FAIL full_extra_dropped: got count=%0d want 4", ifb.loadCount);
    else passed++;
    @(negedge clk);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0 && i < 5) begin
        exp_word = {8'(4*i-3), 8'(4*i-2), 8'(4*i-1), 8'(4*i)};
        total++;
        if (ifb.instruction !== exp_word || ifb.instructionValid !== 1'b1)
          $display("FAIL full_word%0d: got %h valid=%b want %h valid=1",
                   i-1, ifb.instruction, ifb.instructionValid, exp_word);
        else passed++;
      end else if (i == 5) begin
        total++;
        if (ifb.addressFault !== 1'b1 || ifb.instructionValid !== 1'b0)
          $display("FAIL full_past_end: got fault=%b valid=%b want 1/0",
                   ifb.addressFault, ifb.instructionValid);
        else passed++;
      end
      if (i < 5) ifb.pcAddress = BASE + 32'(4*i);
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    ifa.loadEnable = 1'b1;
    a_byte(8'hA0);
    a_byte(8'hA1);
    a_byte(8'hA2);
    a_byte(8'hA3);
    a_byte(8'hB0);
    @(negedge clk);
    ifa.loadByteValid = 1'b0;
    total++;
    if (ifa.loadCount !== 1)
      $display("FAIL midload_count_before: got %0d want 1", ifa.loadCount);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (ifa.loadReady !== 1'b0 || ifa.loadCount !== 0)
      $display("FAIL midload_async_reset: got ready=%b count=%0d want 0/0",
               ifa.loadReady, ifa.loadCount);
    else passed++;
    ifa.loadEnable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ifa.pcAddress = BASE;
    @(negedge clk);
    total++;
    if (ifa.instruction !== 32'hA0A1_A2A3)
      $display("FAIL midload_word0: got %h want a0a1a2a3", ifa.instruction);
    else passed++;
    ifa.pcAddress = BASE + 32'd4;
    @(negedge clk);
    total++;
    if (ifa.instruction !== 32'h3C01_1001)
      $display("FAIL midload_word1_kept: got %h want 3c011001", ifa.instruction);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_two_words();
    test_partial_and_gaps();
    test_empty_load();
    test_back_to_back_faults();
    test_full_boundary();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
